// File: rtl/bilinear_interp.sv
// Source-pixel interpolator: fetches the neighbours of a mapped coordinate from a fixed-latency RAM.
// Define BILINEAR_INTERP_BILINEAR_EN for 4-tap bilinear filtering; otherwise nearest neighbour is used.
module bilinear_interp #(
   parameter int unsigned SRC_W  = 640,
   parameter int unsigned SRC_H  = 480,
   parameter int unsigned FRAC_W = 8,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [11:0]       s_x_int,
   input  logic [FRAC_W-1:0] s_x_frac,
   input  logic [11:0]       s_y_int,
   input  logic [FRAC_W-1:0] s_y_frac,
   output logic              rd_en,
   output logic [19:0]       rd_addr,
   input  logic [7:0]        rd_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [7:0]        m_pixel,
   output logic              m_oob
);

   localparam int unsigned CRD_W  = 12;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned PIX_W  = 8;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, CALC, OUT} state_e;

   state_e              state_q, state_d;
   logic                s_ready_q, s_ready_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                m_valid_q, m_valid_d;
   logic [PIX_W-1:0]    m_pixel_q, m_pixel_d;
   logic                m_oob_q, m_oob_d;
   logic [RD_LAT-1:0]   vld_q, vld_d;

   logic                oob_c;
   logic                last_cap_c;
   logic [ADDR_W-1:0]   start_addr_c;
   logic [PIX_W-1:0]    result_c;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [CRD_W-1:0] x,
                                                 input logic [CRD_W-1:0] y);
      return ADDR_W'(y) * ADDR_W'(SRC_W) + ADDR_W'(x);
   endfunction

   // Negative coordinates show up as a set sign bit; the unsigned compare covers the far edges.
   assign oob_c = s_x_int[CRD_W-1] | s_y_int[CRD_W-1] |
                  (s_x_int >= CRD_W'(SRC_W)) | (s_y_int >= CRD_W'(SRC_H));

`ifdef BILINEAR_INTERP_BILINEAR_EN
   localparam int unsigned ACC_W = PIX_W + 2*FRAC_W + 2;

   logic [1:0]              cnt_q, cnt_d;
   logic [1:0]              cap_q, cap_d;
   logic [3:0][PIX_W-1:0]   pix_q, pix_d;
   logic [CRD_W-1:0]        x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [FRAC_W-1:0]       fx_q, fx_d, fy_q, fy_d;
   logic [CRD_W-1:0]        x1_c, y1_c;
   logic [ACC_W-1:0]        fx_c, fy_c, sx_c, sy_c, h0_c, h1_c, acc_c, res_c;

   // Neighbour clamping and the weighted sum; pix order is p00, p01, p10, p11.
   always_comb begin
      x1_c         = (s_x_int == CRD_W'(SRC_W - 1)) ? s_x_int : s_x_int + CRD_W'(1);
      y1_c         = (s_y_int == CRD_W'(SRC_H - 1)) ? s_y_int : s_y_int + CRD_W'(1);
      start_addr_c = addr_of(s_x_int, s_y_int);
      fx_c         = ACC_W'(fx_q);
      fy_c         = ACC_W'(fy_q);
      sx_c         = (ACC_W'(1) << FRAC_W) - fx_c;
      sy_c         = (ACC_W'(1) << FRAC_W) - fy_c;
      h0_c         = ACC_W'(pix_q[0]) * sx_c + ACC_W'(pix_q[1]) * fx_c;
      h1_c         = ACC_W'(pix_q[2]) * sx_c + ACC_W'(pix_q[3]) * fx_c;
      acc_c        = h0_c * sy_c + h1_c * fy_c + (ACC_W'(1) << (2*FRAC_W - 1));
      res_c        = acc_c >> (2*FRAC_W);
      result_c     = (res_c > ACC_W'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : PIX_W'(res_c);
      last_cap_c   = (cap_q == 2'd3);
   end
`else
   logic [PIX_W-1:0]        pix_q, pix_d;
   logic [CRD_W-1:0]        xn_c, yn_c;
   logic                    unused_frac_c;

   // Only the half-pixel bit of each fraction decides the rounding direction.
   assign unused_frac_c = ^{s_x_frac[FRAC_W-2:0], s_y_frac[FRAC_W-2:0]};

   always_comb begin
      xn_c = s_x_int + CRD_W'(s_x_frac[FRAC_W-1]);
      yn_c = s_y_int + CRD_W'(s_y_frac[FRAC_W-1]);
      if (xn_c >= CRD_W'(SRC_W)) xn_c = CRD_W'(SRC_W - 1);
      if (yn_c >= CRD_W'(SRC_H)) yn_c = CRD_W'(SRC_H - 1);
      start_addr_c = addr_of(xn_c, yn_c);
      result_c     = pix_q;
      last_cap_c   = 1'b1;
   end
`endif

   // Next-state, read sequencing and capture of returning RAM data.
   always_comb begin
      state_d   = state_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      m_valid_d = m_valid_q;
      m_pixel_d = m_pixel_q;
      m_oob_d   = m_oob_q;
      vld_d     = RD_LAT'({vld_q, rd_en_q});
      pix_d     = pix_q;
`ifdef BILINEAR_INTERP_BILINEAR_EN
      cnt_d     = cnt_q;
      cap_d     = cap_q;
      x0_d      = x0_q;
      x1_d      = x1_q;
      y0_d      = y0_q;
      y1_d      = y1_q;
      fx_d      = fx_q;
      fy_d      = fy_q;
      if (vld_q[RD_LAT-1]) begin
         pix_d[cap_q] = rd_data;
         cap_d        = cap_q + 2'd1;
      end
`else
      if (vld_q[RD_LAT-1]) pix_d = rd_data;
`endif

      case (state_q)
         IDLE: begin
            if (s_valid) begin
               if (oob_c) begin
                  state_d   = OUT;
                  m_valid_d = 1'b1;
                  m_oob_d   = 1'b1;
                  m_pixel_d = '0;
               end else begin
                  state_d   = FETCH;
                  rd_en_d   = 1'b1;
                  rd_addr_d = start_addr_c;
                  m_oob_d   = 1'b0;
`ifdef BILINEAR_INTERP_BILINEAR_EN
                  cnt_d     = 2'd0;
                  cap_d     = 2'd0;
                  x0_d      = s_x_int;
                  x1_d      = x1_c;
                  y0_d      = s_y_int;
                  y1_d      = y1_c;
                  fx_d      = s_x_frac;
                  fy_d      = s_y_frac;
`endif
               end
            end
         end
         FETCH: begin
`ifdef BILINEAR_INTERP_BILINEAR_EN
            // cnt_q indexes the read on the bus this cycle; bit0 selects x1, bit1 selects y1.
            if (cnt_q != 2'd3) begin
               cnt_d     = cnt_q + 2'd1;
               rd_en_d   = 1'b1;
               rd_addr_d = addr_of(cnt_d[0] ? x1_q : x0_q, cnt_d[1] ? y1_q : y0_q);
            end else begin
               state_d = WAIT;
            end
`else
            state_d = WAIT;
`endif
         end
         WAIT: begin
            if (vld_q[RD_LAT-1] && last_cap_c) state_d = CALC;
         end
         CALC: begin
            m_pixel_d = result_c;
            m_valid_d = 1'b1;
            state_d   = OUT;
         end
         OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      s_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         s_ready_q <= 1'b1;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         m_valid_q <= 1'b0;
         m_pixel_q <= '0;
         m_oob_q   <= 1'b0;
         vld_q     <= '0;
         pix_q     <= '0;
`ifdef BILINEAR_INTERP_BILINEAR_EN
         cnt_q     <= '0;
         cap_q     <= '0;
         x0_q      <= '0;
         x1_q      <= '0;
         y0_q      <= '0;
         y1_q      <= '0;
         fx_q      <= '0;
         fy_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         s_ready_q <= s_ready_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         m_valid_q <= m_valid_d;
         m_pixel_q <= m_pixel_d;
         m_oob_q   <= m_oob_d;
         vld_q     <= vld_d;
         pix_q     <= pix_d;
`ifdef BILINEAR_INTERP_BILINEAR_EN
         cnt_q     <= cnt_d;
         cap_q     <= cap_d;
         x0_q      <= x0_d;
         x1_q      <= x1_d;
         y0_q      <= y0_d;
         y1_q      <= y1_d;
         fx_q      <= fx_d;
         fy_q      <= fy_d;
`endif
      end
   end

   assign s_ready = s_ready_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign m_valid = m_valid_q;
   assign m_pixel = m_pixel_q;
   assign m_oob   = m_oob_q;

endmodule

// File: doc/bilinear_interp.md
BILINEAR_INTERP -- requirements
Module: bilinear_interp

Interface
REQ-001 SHALL have parameter SRC_W, default 640: source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 480: source image height in pixels.
REQ-003 SHALL have parameter FRAC_W, default 8: fractional bits of incoming coordinates.
REQ-004 SHALL have parameter RD_LAT, default 2: fixed source-RAM read latency in cycles, range 1..4.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port s_valid  in  1  mapped source coordinate present.
REQ-008 SHALL have port s_ready  out  1  block accepts a coordinate.
REQ-009 SHALL have port s_x_int  in  12  signed integer (floor) part of source x.
REQ-010 SHALL have port s_x_frac  in  FRAC_W  unsigned fractional part of source x.
REQ-011 SHALL have port s_y_int  in  12  signed integer (floor) part of source y.
REQ-012 SHALL have port s_y_frac  in  FRAC_W  unsigned fractional part of source y.
REQ-013 SHALL have port rd_en  out  1  source-RAM read strobe.
REQ-014 SHALL have port rd_addr  out  20  source-RAM address = y*SRC_W + x.
REQ-015 SHALL have port rd_data  in  8  grey pixel, valid RD_LAT cycles after the matching rd_en.
REQ-016 SHALL have port m_valid  out  1  interpolated pixel present.
REQ-017 SHALL have port m_ready  in  1  downstream accepts pixel.
REQ-018 SHALL have port m_pixel  out  8  interpolated grey value.
REQ-019 SHALL have port m_oob  out  1  coordinate was outside source; m_pixel forced 0.

Function
REQ-020 SHALL implement FSM IDLE -> FETCH -> WAIT -> CALC -> OUT -> IDLE; IDLE -> OUT directly for out-of-bounds input.
REQ-021 SHALL drive s_ready=1 only in IDLE; a transfer occurs on s_valid&&s_ready (cycle 0).
REQ-022 SHALL classify input as out-of-bounds when s_x_int<0, s_x_int>=SRC_W, s_y_int<0 or s_y_int>=SRC_H.
REQ-023 SHALL, in FETCH, pulse rd_en in cycles 1..4 with addresses (x0,y0),(x1,y0),(x0,y1),(x1,y1), where x1=min(x0+1,SRC_W-1) and y1=min(y0+1,SRC_H-1).
REQ-024 SHALL capture rd_data in cycle k+RD_LAT for the read issued in cycle k, tracked by a reset-cleared valid shift register.
REQ-025 SHALL compute, with S=2^FRAC_W, fx=s_x_frac, fy=s_y_frac: ((p00*(S-fx)+p01*fx)*(S-fy)+(p10*(S-fx)+p11*fx)*fy + 2^(2*FRAC_W-1)) >> 2*FRAC_W, using an intermediate of at least 8+2*FRAC_W+2 bits.
REQ-026 SHALL saturate the result to 255 before loading m_pixel.
REQ-027 SHALL assert m_valid first in cycle RD_LAT+6 for in-bounds input, and in cycle 1 with m_oob=1, m_pixel=0 and no rd_en for out-of-bounds input.
REQ-028 SHALL hold m_valid, m_pixel and m_oob stable while m_valid&&!m_ready, and return to IDLE in the cycle after m_valid&&m_ready.
REQ-029 SHALL keep rd_en=0 outside FETCH; rd_addr is don't-care when rd_en=0 but SHALL hold its last value.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE, m_valid=0, m_pixel=0, m_oob=0, rd_en=0, rd_addr=0, and clear the read-valid pipeline and captured pixels.
REQ-031 SHALL discard any rd_data returning after a mid-operation reset; s_ready=1 in the first cycle after rst_n rises.

Configuration
REQ-032 SHALL, with macro BILINEAR_INTERP_BILINEAR_EN defined, behave per REQ-023..REQ-027.
REQ-033 SHALL, without BILINEAR_INTERP_BILINEAR_EN, use nearest neighbour: one read in cycle 1 at (min(x0+fx[FRAC_W-1],SRC_W-1), min(y0+fy[FRAC_W-1],SRC_H-1)), m_pixel=rd_data, m_valid first in cycle RD_LAT+3; out-of-bounds handling is unchanged.

Verification (defaults; RAM model pixel(x,y)=(x+y) mod 256)
REQ-034 SHALL cover: x=10.0, y=20.0 -> rd_addr 12810,12811,13450,13451 in cycles 1..4; m_pixel=30, m_valid in cycle 8.
REQ-035 SHALL cover: x=10+128/256, y=20+128/256 -> neighbours 30,31,31,32; m_pixel=31.
REQ-036 SHALL cover: x=639+200/256, y=5.0 -> x1 clamped to 639; m_pixel=132.
REQ-037 SHALL cover: x_int=-1, y=0 -> no rd_en; m_valid in cycle 1 with m_oob=1 and m_pixel=0.
REQ-038 SHALL cover: m_ready held low for 5 cycles after m_valid -> outputs stable and s_ready=0; exactly one transfer when m_ready rises.
REQ-039 SHALL cover: rst_n low during cycle 3 of a fetch -> rd_en=0 immediately; no m_valid afterwards; s_ready=1 after release.
